// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix size, frame-result
// encoding, report FSM states and the per-row priority encoder.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } key_res_t;

    localparam key_res_t KEY_NONE = '{hit: 1'b0, code: 4'h0};

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } rpt_state_t;

    // Lowest pressed column of one row wins; code is row*4 + column.
    function automatic key_res_t first_key(input logic [1:0] row, input logic [COLS-1:0] pressed);
        key_res_t res;
        res = KEY_NONE;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (pressed[c]) begin
                res.hit  = 1'b1;
                res.code = {row, 2'(c)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines.
// Resets to all-ones, the idle level of the pulled-up columns.
module keypad_col_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] col_s
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = col_n;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign col_s = sync_q;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: row multiplexing, frame-level debounce and a
// press-reporting FSM that emits one strobe per accepted key press.
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int ROW_DWELL       = 2500,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int             DW         = $clog2(ROW_DWELL);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(ROW_DWELL - 1);
    localparam logic [3:0]     DB_TARGET  = 4'(DEBOUNCE_FRAMES);

    logic [3:0]      col_s;

    logic [DW-1:0]   dwell_q, dwell_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [ROWS-1:0] row_n_q, row_n_d;
    key_res_t        acc_q, acc_d;
    key_res_t        cand_q, cand_d;
    logic [3:0]      cnt_q, cnt_d;
    rpt_state_t      state_q, state_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;

    logic            sample;
    logic            frame_close;
    key_res_t        row_res;
    key_res_t        frame_res;
    logic            stable;

    keypad_col_sync u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .col_n (col_n),
        .col_s (col_s)
    );

    always_comb begin
        dwell_d     = dwell_q;
        row_idx_d   = row_idx_q;
        acc_d       = acc_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;

        sample      = (dwell_q == DWELL_LAST);
        frame_close = sample && (row_idx_q == 2'd3);
        row_res     = first_key(row_idx_q, ~col_s);
        // An earlier row's hit in this frame always outranks later rows.
        frame_res   = acc_q.hit ? acc_q : row_res;

        if (sample) begin
            dwell_d   = '0;
            row_idx_d = row_idx_q + 2'd1;
            acc_d     = frame_close ? KEY_NONE : frame_res;
        end else begin
            dwell_d   = dwell_q + 1'b1;
        end

        row_n_d = ~(4'b0001 << row_idx_d);

        if (frame_close) begin
            if (frame_res == cand_q) begin
                if (cnt_q < DB_TARGET) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cand_d = frame_res;
                cnt_d  = 4'd1;
            end
        end

        // Judged on the freshly updated debounce state so the strobe lands
        // one cycle after the closing sample.
        stable = frame_close && (cnt_d >= DB_TARGET);
    end

    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        case (state_q)
            RELEASED: begin
                if (stable && cand_d.hit) begin
                    state_d     = HELD;
                    key_code_d  = cand_d.code;
                    key_valid_d = 1'b1;
                end
            end
            HELD: begin
                // A different stable key while held is ignored until released.
                if (stable && !cand_d.hit) begin
                    state_d = RELEASED;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q     <= '0;
            row_idx_q   <= 2'd0;
            row_n_q     <= 4'b1110;
            acc_q       <= KEY_NONE;
            cand_q      <= KEY_NONE;
            cnt_q       <= 4'd0;
            state_q     <= RELEASED;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            row_idx_q   <= row_idx_d;
            row_n_q     <= row_n_d;
            acc_q       <= acc_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign row_n     = row_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == HELD);

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Frame-aligned directed test of keypad_scan_4x4 with a behavioural keypad
// matrix (ROW_DWELL=4, DEBOUNCE_FRAMES=2, so one frame is 16 cycles).
module tb_keypad_scan_4x4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;
    int          checks;
    int          errors;
    int          frame_no;

    typedef struct {
        logic [15:0] keys;
        logic        ev;
        logic [3:0]  ec;
        logic        eh;
    } vec_t;

    vec_t vecs[$];

    keypad_scan_4x4 #(
        .ROW_DWELL       (4),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its column to a low-driven row.
    always_comb begin
        col_n = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!row_n[r] && pressed[r*4 + c]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (frame %0d): got %0h, expected %0h", name, frame_no, act, exp);
        end
    endtask

    task automatic add_vec(input logic [15:0] keys, input logic ev, input logic [3:0] ec, input logic eh);
        vec_t v;
        v.keys = keys;
        v.ev   = ev;
        v.ec   = ec;
        v.eh   = eh;
        vecs.push_back(v);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_row_n"}, row_n, 4'b1110);
        chk({tag, "_key_code"}, key_code, 4'h0);
        chk({tag, "_key_valid"}, key_valid, 1'b0);
        chk({tag, "_key_held"}, key_held, 1'b0);
    endtask

    // Starts at the first cycle of a frame; ends just after its closing edge.
    task automatic run_frame(input logic [15:0] keys, input logic ev, input logic [3:0] ec, input logic eh);
        int         stray;
        int         rowbad;
        logic [3:0] one;
        logic [3:0] exp_row;
        stray   = 0;
        rowbad  = 0;
        one     = 4'b0001;
        pressed = keys;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1;
            exp_row = ~(one << (((j + 1) % 16) / 4));
            if (row_n !== exp_row) rowbad++;
            if (j < 15 && key_valid !== 1'b0) stray++;
        end
        chk("row_n_sequence", rowbad, 0);
        chk("stray_key_valid", stray, 0);
        chk("key_valid", key_valid, ev);
        chk("key_code", key_code, ec);
        chk("key_held", key_held, eh);
        frame_no++;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        frame_no = 0;
        pressed  = 16'h0000;
        rst_n    = 1'b0;

        // Reset and idle
        for (int i = 0; i < 10; i++) add_vec(16'h0000, 1'b0, 4'h0, 1'b0);
        // Single press of key 6, then release
        add_vec(16'h0040, 1'b0, 4'h0, 1'b0);
        add_vec(16'h0040, 1'b1, 4'h6, 1'b1);
        for (int i = 0; i < 3; i++) add_vec(16'h0040, 1'b0, 4'h6, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h6, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h6, 1'b0);
        add_vec(16'h0000, 1'b0, 4'h6, 1'b0);
        // Bounce on key F
        add_vec(16'h8000, 1'b0, 4'h6, 1'b0);
        add_vec(16'h0000, 1'b0, 4'h6, 1'b0);
        add_vec(16'h8000, 1'b0, 4'h6, 1'b0);
        add_vec(16'h0000, 1'b0, 4'h6, 1'b0);
        add_vec(16'h0000, 1'b0, 4'h6, 1'b0);
        // Row priority: 9 and 5 together
        add_vec(16'h0220, 1'b0, 4'h6, 1'b0);
        add_vec(16'h0220, 1'b1, 4'h5, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h5, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h5, 1'b0);
        // Column priority: 4 and 7 together
        add_vec(16'h0090, 1'b0, 4'h5, 1'b0);
        add_vec(16'h0090, 1'b1, 4'h4, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h4, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h4, 1'b0);
        // Corner keys 0 and F together
        add_vec(16'h8001, 1'b0, 4'h4, 1'b0);
        add_vec(16'h8001, 1'b1, 4'h0, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h0, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h0, 1'b0);
        // Roll-over 3 -> C, then release and press C again
        add_vec(16'h0008, 1'b0, 4'h0, 1'b0);
        add_vec(16'h0008, 1'b1, 4'h3, 1'b1);
        for (int i = 0; i < 3; i++) add_vec(16'h1000, 1'b0, 4'h3, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h3, 1'b1);
        add_vec(16'h0000, 1'b0, 4'h3, 1'b0);
        add_vec(16'h1000, 1'b0, 4'h3, 1'b0);
        add_vec(16'h1000, 1'b1, 4'hC, 1'b1);
        add_vec(16'h0000, 1'b0, 4'hC, 1'b1);
        add_vec(16'h0000, 1'b0, 4'hC, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_frame(vecs[i].keys, vecs[i].ev, vecs[i].ec, vecs[i].eh);

        // Reset one frame into a press of A, key kept down through reset
        run_frame(16'h0400, 1'b0, 4'hC, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(16'h0400, 1'b0, 4'h0, 1'b0);
        run_frame(16'h0400, 1'b1, 4'hA, 1'b1);
        run_frame(16'h0400, 1'b0, 4'hA, 1'b1);
        run_frame(16'h0000, 1'b0, 4'hA, 1'b1);
        run_frame(16'h0000, 1'b0, 4'hA, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
